gfifo_step_batcher: RTL and testbench
=====================================

# gfifo_step_batcher

Emulator-side producer of the difftest step stream for the deferred-result gfifo path. It collects per-cycle difftest step events from the cores into an accumulator and emits batched, saturated step counts on a one-cycle `step` bus for the gfifo step consumer. It stops emitting permanently once the host-side result flag (`simv_result`) reports completion or mismatch, so no steps reach the host after the verdict.

## Interface

Parameters:
- STEP_WIDTH, 8, width of emitted step bus; max emission is 2^STEP_WIDTH-1.
- ACC_WIDTH, 16, accumulator width; must be > STEP_WIDTH.
- BATCH_SIZE, 64, accumulator level that triggers emission; 1 ≤ BATCH_SIZE < 2^ACC_WIDTH.
- FLUSH_TIMEOUT, 1000, idle-emission timeout in cycles; ≥ 1.

Ports:
- clock  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  accumulation and timer enable.
- tick  input  4  number of step events this cycle, 0..15.
- flush_req  input  1  force emission of pending steps.
- simv_result  input  1  host verdict; level, sampled each edge.
- step  output  STEP_WIDTH  emitted count; nonzero only in emission cycles.
- pending  output  ACC_WIDTH  current accumulator value.
- halted  output  1  block permanently stopped.
- overflow  output  1  sticky; accumulator saturated and events were lost.

## Operation

- States: IDLE (acc == 0), ACCUM (acc > 0), HALT. All outputs and state are zero/IDLE while reset is low, asserted asynchronously.
- The emission decision uses the registered acc only, never the incoming `tick`. The block emits on an edge when not in HALT, acc > 0, and any of these holds:
  - acc ≥ BATCH_SIZE;
  - timer == FLUSH_TIMEOUT-1;
  - flush_req == 1.
- On emission:
  - e = min(acc, 2^STEP_WIDTH-1);
  - step <= e;
  - acc <= acc - e + add;
  - timer <= 0.
- Without emission: step <= 0 and acc <= acc + add.
- add = tick if enable else 0.
- acc saturates at 2^ACC_WIDTH-1. If the sum would exceed that, acc clamps and overflow is set; overflow clears only on reset.
- timer: increments when enable && acc > 0 && no emission; cleared when acc == 0. It holds when enable is low.
- flush_req is honoured regardless of enable. flush_req with acc == 0 does nothing.
- State follows acc after update: 0 → IDLE, otherwise ACCUM.
- HALT: if simv_result == 1 at an edge, from any non-HALT state:
  - next state is HALT and halted <= 1;
  - step <= 0, including any emission that would have happened on that edge;
  - acc and pending freeze, and ticks are discarded.
- HALT exits only via reset. simv_result deasserting later has no effect.
- simv_result takes priority over emission and flush_req on the same edge.

## Timing

- `step` is registered. A tick in cycle n is reflected in pending in cycle n+1. The earliest resulting nonzero step appears in cycle n+2.
- Back-to-back emissions in consecutive cycles are legal while acc stays ≥ BATCH_SIZE, e.g. during a saturated backlog.
- halted asserts in the cycle after simv_result is first sampled high. step is 0 from that cycle on.
- Reset values: step = 0, pending = 0, halted = 0, overflow = 0, timer = 0, state IDLE.
- Reset deassertion takes effect on the first rising edge after release. No tick is lost if tick is held across release.

## Test plan

- Defaults, enable = 1, tick = 1 every cycle from cycle 0 → pending = 64 in cycle 64; step = 64 in cycle 65, otherwise 0; pending = 1 in cycle 65; then step = 64 every 64 cycles.
- Defaults, one tick = 1 in cycle 0 then tick = 0 → pending = 1 from cycle 1; step = 1 in cycle 1001 only; pending = 0 after.
- BATCH_SIZE = 512, tick = 15 for 35 cycles then 0 → no emission at 510; step = 255 once acc reaches 525; pending = 270 held; step = 255 then 15 on later timeout edges.
- tick = 3 each cycle, simv_result raised in cycle 20 → halted = 1 and step = 0 from cycle 21; pending frozen at its cycle-21 value indefinitely; flush_req ignored.
- Assert reset low asynchronously mid-batch (pending = 40) between edges → step, pending, halted, overflow read 0 immediately; after release, accumulation restarts from 0.
- ACC_WIDTH = 9, STEP_WIDTH = 8, BATCH_SIZE = 511, enable high, tick = 15 with flush_req low → pending clamps at 511; emission of 255 follows; overflow = 1 and stays set.

Source files
------------

// File: rtl/gfifo_step_batcher.sv
// Difftest step batcher: accumulates per-cycle step events and emits saturated
// batch counts on a one-cycle step bus until the host verdict halts it for good.
module gfifo_step_batcher #(
    parameter int STEP_WIDTH    = 8,
    parameter int ACC_WIDTH     = 16,
    parameter int BATCH_SIZE    = 64,
    parameter int FLUSH_TIMEOUT = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3:0]            tick,
    input  logic                  flush_req,
    input  logic                  simv_result,
    output logic [STEP_WIDTH-1:0] step,
    output logic [ACC_WIDTH-1:0]  pending,
    output logic                  halted,
    output logic                  overflow
);

    localparam int TIMER_WIDTH = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [ACC_WIDTH-1:0]   STEP_MAX   = ACC_WIDTH'((64'd1 << STEP_WIDTH) - 64'd1);
    localparam logic [ACC_WIDTH-1:0]   ACC_MAX    = {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0]   BATCH      = ACC_WIDTH'(BATCH_SIZE);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HALT
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [TIMER_WIDTH-1:0] timer;

    logic                 acc_nz;
    logic                 emit;
    logic [ACC_WIDTH-1:0] emit_amt;
    logic [ACC_WIDTH-1:0] base;
    logic [3:0]           add;
    logic [ACC_WIDTH:0]   sum;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] acc_next;

    // Emission is decided from the registered accumulator only; this cycle's
    // tick is folded in after the drain so it is never emitted early.
    always_comb begin
        acc_nz   = (acc != '0);
        emit     = (state != S_HALT) && acc_nz &&
                   ((acc >= BATCH) || (timer == TIMER_LAST) || flush_req);
        emit_amt = (acc > STEP_MAX) ? STEP_MAX : acc;
        base     = emit ? (acc - emit_amt) : acc;
        add      = enable ? tick : 4'd0;
        sum      = {1'b0, base} + (ACC_WIDTH + 1)'(add);
        sum_ovf  = (sum > {1'b0, ACC_MAX});
        acc_next = sum_ovf ? ACC_MAX : sum[ACC_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block is moot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            timer    <= '0;
            step     <= '0;
            halted   <= 1'b0;
            overflow <= 1'b0;
        end else if (state == S_HALT) begin
            step <= '0;
        end else if (simv_result) begin
            // The verdict beats any emission due on this same edge.
            state  <= S_HALT;
            halted <= 1'b1;
            step   <= '0;
        end else begin
            step <= emit ? emit_amt[STEP_WIDTH-1:0] : '0;
            acc  <= acc_next;
            if (sum_ovf) begin
                overflow <= 1'b1;
            end
            if (emit || !acc_nz) begin
                timer <= '0;
            end else if (enable) begin
                timer <= timer + TIMER_WIDTH'(1);
            end
            state <= (acc_next == '0) ? S_IDLE : S_ACCUM;
        end
    end

    assign pending = acc;

endmodule

// File: tb/tb_gfifo_step_batcher.sv
// Self-checking bench: default and narrow-accumulator instances share stimulus
// and are compared every cycle against a behavioural step-count model.
module tb_gfifo_step_batcher;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] tick;
    logic       flush_req;
    logic       simv_result;

    logic [7:0]  step_a;
    logic [15:0] pending_a;
    logic        halted_a;
    logic        overflow_a;

    logic [7:0]  step_b;
    logic [8:0]  pending_b;
    logic        halted_b;
    logic        overflow_b;

    int tests    = 0;
    int failures = 0;

    gfifo_step_batcher dut_a (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .tick        (tick),
        .flush_req   (flush_req),
        .simv_result (simv_result),
        .step        (step_a),
        .pending     (pending_a),
        .halted      (halted_a),
        .overflow    (overflow_a)
    );

    gfifo_step_batcher #(
        .STEP_WIDTH    (8),
        .ACC_WIDTH     (9),
        .BATCH_SIZE    (511),
        .FLUSH_TIMEOUT (1000)
    ) dut_b (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .tick        (tick),
        .flush_req   (flush_req),
        .simv_result (simv_result),
        .step        (step_b),
        .pending     (pending_b),
        .halted      (halted_b),
        .overflow    (overflow_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int acc;
        int timer;
        int step;
        bit halted;
        bit ovf;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t model_reset();
        mdl_t r;
        r.acc = 0; r.timer = 0; r.step = 0; r.halted = 1'b0; r.ovf = 1'b0;
        return r;
    endfunction

    // One rising edge of the spec's rules in plain integer arithmetic.
    function automatic mdl_t model_next(mdl_t s, int batch, int acc_max, int step_max,
                                        int ft, bit en, int tk, bit fl, bit sv);
        mdl_t n;
        int   add;
        int   e;
        bit   fire;
        n = s;
        n.step = 0;
        if (s.halted) return n;
        if (sv) begin
            n.halted = 1'b1;
            return n;
        end
        add  = en ? tk : 0;
        fire = (s.acc > 0) && ((s.acc >= batch) || (s.timer == ft - 1) || fl);
        e    = fire ? ((s.acc < step_max) ? s.acc : step_max) : 0;
        n.step = e;
        n.acc  = s.acc - e + add;
        if (n.acc > acc_max) begin
            n.acc = acc_max;
            n.ovf = 1'b1;
        end
        if (fire || s.acc == 0) n.timer = 0;
        else if (en) n.timer = s.timer + 1;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic compare_all();
        check("a_step",     32'(step_a),     32'(ma.step));
        check("a_pending",  32'(pending_a),  32'(ma.acc));
        check("a_halted",   32'(halted_a),   32'(ma.halted));
        check("a_overflow", 32'(overflow_a), 32'(ma.ovf));
        check("b_step",     32'(step_b),     32'(mb.step));
        check("b_pending",  32'(pending_b),  32'(mb.acc));
        check("b_halted",   32'(halted_b),   32'(mb.halted));
        check("b_overflow", 32'(overflow_b), 32'(mb.ovf));
    endtask

    // Advance one edge with the currently driven inputs, then check both DUTs.
    task automatic cycle();
        @(posedge clock);
        #1;
        ma = model_next(ma, 64, 65535, 255, 1000, enable, int'(tick), flush_req, simv_result);
        mb = model_next(mb, 511, 511, 255, 1000, enable, int'(tick), flush_req, simv_result);
        compare_all();
    endtask

    // Asynchronous assert between edges, immediate check, release on a falling edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    logic [15:0] frozen;

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        tick        = 4'd0;
        flush_req   = 1'b0;
        simv_result = 1'b0;
        ma = model_reset();
        mb = model_reset();

        #2;
        check("rst_step",     32'(step_a),     32'd0);
        check("rst_pending",  32'(pending_a),  32'd0);
        check("rst_halted",   32'(halted_a),   32'd0);
        check("rst_overflow", 32'(overflow_a), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Steady one tick per cycle: batch of 64 emitted every 64 cycles.
        enable = 1'b1;
        tick   = 4'd1;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            if (i == 64) check("tp1_pending64", 32'(pending_a), 32'd64);
            if (i == 65) begin
                check("tp1_step64",   32'(step_a),    32'd64);
                check("tp1_pending1", 32'(pending_a), 32'd1);
            end
            if (i == 129) check("tp1_step64_again", 32'(step_a), 32'd64);
        end

        // Asynchronous reset mid-batch.
        do_reset();
        for (int i = 1; i <= 40; i++) cycle();
        check("mid_pending40", 32'(pending_a), 32'd40);
        do_reset();
        check("mid_rst_pending", 32'(pending_a), 32'd0);

        // Single tick held across release, then idle until the flush timeout.
        for (int j = 1; j <= 1010; j++) begin
            cycle();
            tick = 4'd0;
            if (j == 1)    check("tp2_no_tick_lost", 32'(pending_a), 32'd1);
            if (j == 1000) check("tp2_pre_timeout",  32'(step_a),    32'd0);
            if (j == 1001) check("tp2_timeout_step", 32'(step_a),    32'd1);
            if (j == 1002) check("tp2_drained",      32'(pending_a), 32'd0);
        end

        // Narrow accumulator saturates before its batch level can drain it.
        do_reset();
        tick = 4'd15;
        for (int j = 1; j <= 40; j++) begin
            cycle();
            if (j == 34) check("ovf_pending510", 32'(pending_b),  32'd510);
            if (j == 35) begin
                check("ovf_clamp511", 32'(pending_b),  32'd511);
                check("ovf_set",      32'(overflow_b), 32'd1);
            end
            if (j == 36) check("ovf_emit255", 32'(step_b), 32'd255);
        end
        check("ovf_sticky", 32'(overflow_b), 32'd1);

        // Random traffic with enable gaps and sporadic flushes.
        for (int j = 0; j < 1500; j++) begin
            enable    = ($urandom_range(3) != 0);
            tick      = 4'($urandom_range(15));
            flush_req = ($urandom_range(7) == 0);
            cycle();
        end
        flush_req = 1'b0;

        // Verdict wins over a pending flush and freezes the block for good.
        do_reset();
        enable = 1'b1;
        tick   = 4'd3;
        for (int j = 1; j <= 20; j++) cycle();
        check("halt_pre_pending", 32'(pending_a), 32'd60);
        simv_result = 1'b1;
        flush_req   = 1'b1;
        cycle();
        check("halt_set",         32'(halted_a),  32'd1);
        check("halt_step0",       32'(step_a),    32'd0);
        check("halt_frozen_init", 32'(pending_a), 32'd60);
        frozen      = pending_a;
        simv_result = 1'b0;
        for (int j = 0; j < 50; j++) begin
            tick = 4'($urandom_range(15));
            cycle();
        end
        check("halt_frozen_later", 32'(pending_a), 32'(frozen));
        check("halt_stays",        32'(halted_a),  32'd1);
        flush_req = 1'b0;

        do_reset();
        cycle();
        check("post_halt_clear", 32'(halted_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
